// File: rtl/std_mem_d1_arbiter_if.sv
// std_mem_d1_arbiter_if
//   Bundles the requester-side go/done bus and the shared std_mem_d1 port
//   seen by std_mem_d1_arbiter.
//   slave  : arbiter view (takes requests, drives the memory port)
//   master : requester/memory view (drives requests and memory responses)
//   Signals:
//     go, write_en          per-requester request and direction
//     addr0, write_data     per-requester packed address / write word
//     read_data, done       per-requester registered read result / done pulse
//     busy                  arbiter not idle
//     mem_addr0, mem_write_data, mem_write_en   to std_mem_d1
//     mem_read_data, mem_done                   from std_mem_d1
interface std_mem_d1_arbiter_if #(
    parameter int WIDTH     = 32,
    parameter int IDX_SIZE  = 4,
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]          go;
    logic [NUM_PORTS-1:0]          write_en;
    logic [NUM_PORTS*IDX_SIZE-1:0] addr0;
    logic [NUM_PORTS*WIDTH-1:0]    write_data;
    logic [NUM_PORTS*WIDTH-1:0]    read_data;
    logic [NUM_PORTS-1:0]          done;
    logic                          busy;
    logic [IDX_SIZE-1:0]           mem_addr0;
    logic [WIDTH-1:0]              mem_write_data;
    logic                          mem_write_en;
    logic [WIDTH-1:0]              mem_read_data;
    logic                          mem_done;

    modport slave (
        input  go, write_en, addr0, write_data, mem_read_data, mem_done,
        output read_data, done, busy, mem_addr0, mem_write_data, mem_write_en
    );

    modport master (
        output go, write_en, addr0, write_data, mem_read_data, mem_done,
        input  read_data, done, busy, mem_addr0, mem_write_data, mem_write_en
    );
endinterface

// File: rtl/std_mem_d1_arbiter.sv
// std_mem_d1_arbiter
//   Round-robin arbiter that shares one std_mem_d1 among NUM_PORTS Calyx
//   requesters using the go/done handshake. One transaction at a time is
//   serialised onto the memory port; each requester gets its own registered
//   read_data slice and a one-cycle done pulse.
//   Ports:
//     clk    clock, all state on posedge
//     reset  synchronous reset, active-low
//     bus    std_mem_d1_arbiter_if.slave (requests, responses, memory port)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting; samples go and latches the round-robin winner
//   READ   | latched address on memory, read word captured at cycle end
//   WRITE  | single-cycle mem_write_en with latched address/data
//   WAIT   | waiting for mem_done of the issued write
//   DONE   | done[sel] pulsed for this cycle
module std_mem_d1_arbiter #(
    parameter int WIDTH     = 32,
    parameter int IDX_SIZE  = 4,
    parameter int NUM_PORTS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    std_mem_d1_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    generate
        if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : error_unsupported_bitwidth
            $fatal(1, "std_mem_d1_arbiter: NUM_PORTS must be 2..8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [PTR_W-1:0]           rr_q;
    logic [PTR_W-1:0]           sel_q;
    logic [IDX_SIZE-1:0]        addr_q;
    logic [WIDTH-1:0]           data_q;
    logic [NUM_PORTS*WIDTH-1:0] read_data_q;

    logic                       found;
    logic [PTR_W-1:0]           winner;
    logic [NUM_PORTS-1:0]       done_d;

    // First requester at or above the rr pointer, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            automatic int idx = (int'(rr_q) + k) % NUM_PORTS;
            if (!found && bus.go[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found) state_d = bus.write_en[winner] ? S_WRITE : S_READ;
            S_READ:  state_d = S_DONE;
            S_WRITE: state_d = S_WAIT;
            S_WAIT:  if (bus.mem_done) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && found) begin
                sel_q  <= winner;
                addr_q <= bus.addr0[winner*IDX_SIZE +: IDX_SIZE];
                data_q <= bus.write_data[winner*WIDTH +: WIDTH];
                rr_q   <= PTR_W'((int'(winner) + 1) % NUM_PORTS);
            end
            if (state_q == S_READ) begin
                read_data_q[sel_q*WIDTH +: WIDTH] <= bus.mem_read_data;
            end
        end
    end

    always_comb begin
        done_d = '0;
        if (state_q == S_DONE) done_d[sel_q] = 1'b1;
    end

    // Latched address/data stay on the memory port between transactions too;
    // only mem_write_en qualifies them.
    assign bus.done           = done_d;
    assign bus.read_data      = read_data_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.mem_addr0      = addr_q;
    assign bus.mem_write_data = data_q;
    assign bus.mem_write_en   = (state_q == S_WRITE);
endmodule

// File: tb/tb_std_mem_d1_arbiter.sv
module tb_std_mem_d1_arbiter;
    localparam int WIDTH     = 32;
    localparam int IDX_SIZE  = 4;
    localparam int NUM_PORTS = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    std_mem_d1_arbiter_if #(.WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE), .NUM_PORTS(NUM_PORTS)) bus ();

    std_mem_d1_arbiter #(.WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE), .NUM_PORTS(NUM_PORTS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // std_mem_d1 model: combinational read, registered done one cycle after
    // write_en, optionally stretched by stall_n extra cycles.
    logic [WIDTH-1:0] mem [0:15];
    bit               init_done = 1'b0;
    bit               pend = 1'b0;
    int               cnt = 0;
    int               stall_n = 0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            init_done <= 1'b1;
        end else if (bus.mem_write_en) begin
            mem[bus.mem_addr0] <= bus.mem_write_data;
        end
        if (bus.mem_write_en) begin
            pend <= 1'b1;
            cnt  <= stall_n;
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end
    end

    assign bus.mem_read_data = mem[bus.mem_addr0];
    assign bus.mem_done      = pend && (cnt == 0);

    int wen_cnt   = 0;
    int done1_cnt = 0;
    always @(posedge clk) begin
        if (bus.mem_write_en) wen_cnt   <= wen_cnt + 1;
        if (bus.done[1])      done1_cnt <= done1_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int base;

    initial begin
        reset          = 1'b0;
        bus.go         = '0;
        bus.write_en   = '0;
        bus.addr0      = '0;
        bus.write_data = '0;

        // 1. reset
        tick();
        tick();
        check("rst_done",    64'(bus.done), 64'h0);
        check("rst_busy",    64'(bus.busy), 64'h0);
        check("rst_wen",     64'(bus.mem_write_en), 64'h0);
        check("rst_rdata",   64'(bus.read_data), 64'h0);
        check("rst_maddr",   64'(bus.mem_addr0), 64'h0);
        check("rst_mwdata",  64'(bus.mem_write_data), 64'h0);
        reset = 1'b1;
        tick();
        check("post_rst_busy", 64'(bus.busy), 64'h0);

        // 2. port0 write addr 3 then read back
        bus.go         = 2'b01;
        bus.write_en   = 2'b01;
        bus.addr0      = {4'd0, 4'd3};
        bus.write_data = {32'h0, 32'hDEAD_BEEF};
        tick();
        check("wr_wen_p1",   64'(bus.mem_write_en), 64'h1);
        check("wr_addr_p1",  64'(bus.mem_addr0), 64'h3);
        check("wr_data_p1",  64'(bus.mem_write_data), 64'hDEAD_BEEF);
        check("wr_busy_p1",  64'(bus.busy), 64'h1);
        check("wr_done_p1",  64'(bus.done), 64'h0);
        tick();
        check("wr_wen_p2",   64'(bus.mem_write_en), 64'h0);
        check("wr_done_p2",  64'(bus.done), 64'h0);
        tick();
        check("wr_done_p3",  64'(bus.done), 64'h1);
        bus.go = 2'b00;
        tick();
        check("wr_done_p4",  64'(bus.done), 64'h0);
        check("wr_busy_p4",  64'(bus.busy), 64'h0);

        bus.go       = 2'b01;
        bus.write_en = 2'b00;
        tick();
        check("rd_busy_p1",  64'(bus.busy), 64'h1);
        check("rd_addr_p1",  64'(bus.mem_addr0), 64'h3);
        check("rd_done_p1",  64'(bus.done), 64'h0);
        tick();
        check("rd_done_p2",  64'(bus.done), 64'h1);
        check("rd_data_p2",  64'(bus.read_data[31:0]), 64'hDEAD_BEEF);
        bus.go = 2'b00;
        tick();
        check("rd_done_p3",  64'(bus.done), 64'h0);

        // 3. both ports reading, grants alternate starting at port 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst2_rdata",  64'(bus.read_data), 64'h0);
        bus.addr0    = {4'd6, 4'd5};
        bus.write_en = 2'b00;
        bus.go       = 2'b11;
        for (int g = 0; g < 4; g++) begin
            automatic int p = g % 2;
            tick();
            check("rr_busy",  64'(bus.busy), 64'h1);
            check("rr_addr",  64'(bus.mem_addr0), 64'(5 + p));
            check("rr_done0", 64'(bus.done), 64'h0);
            tick();
            check("rr_done1", 64'(bus.done), 64'(1 << p));
            if (p == 0) check("rr_rdata0", 64'(bus.read_data[31:0]),  64'h1000_0005);
            else        check("rr_rdata1", 64'(bus.read_data[63:32]), 64'h1000_0006);
            tick();
            check("rr_done2", 64'(bus.done), 64'h0);
        end
        bus.go = 2'b00;
        check("rr_hold0", 64'(bus.read_data[31:0]), 64'h1000_0005);

        // 4. port1 write queued behind port0 read
        base         = wen_cnt;
        bus.go       = 2'b01;
        bus.write_en = 2'b00;
        bus.addr0    = {4'd7, 4'd5};
        tick();
        bus.go         = 2'b11;
        bus.write_en   = 2'b10;
        bus.write_data = {32'hCAFE_F00D, 32'h0};
        check("q_wen_rd",   64'(bus.mem_write_en), 64'h0);
        tick();
        check("q_done0",    64'(bus.done), 64'h1);
        check("q_wen_dn",   64'(bus.mem_write_en), 64'h0);
        bus.go = 2'b10;
        tick();
        check("q_idle",     64'(bus.busy), 64'h0);
        check("q_wen_idle", 64'(bus.mem_write_en), 64'h0);
        tick();
        check("q_wen",      64'(bus.mem_write_en), 64'h1);
        check("q_addr",     64'(bus.mem_addr0), 64'h7);
        check("q_wdata",    64'(bus.mem_write_data), 64'hCAFE_F00D);
        tick();
        tick();
        check("q_done1",    64'(bus.done), 64'h2);
        bus.go = 2'b00;
        tick();
        check("q_wen_cnt",  64'(wen_cnt - base), 64'h1);
        check("q_mem7",     64'(mem[7]), 64'hCAFE_F00D);

        // 5. reset during WAIT of a write
        bus.go         = 2'b01;
        bus.write_en   = 2'b01;
        bus.addr0      = {4'd6, 4'd9};
        bus.write_data = {32'h0, 32'h1234_5678};
        tick();
        tick();
        check("ab_wait_busy", 64'(bus.busy), 64'h1);
        reset  = 1'b0;
        bus.go = 2'b00;
        tick();
        check("ab_busy",  64'(bus.busy), 64'h0);
        check("ab_done",  64'(bus.done), 64'h0);
        check("ab_maddr", 64'(bus.mem_addr0), 64'h0);
        reset = 1'b1;
        tick();
        check("ab_done2", 64'(bus.done), 64'h0);
        check("ab_mem9",  64'(mem[9]), 64'h1234_5678);
        bus.go       = 2'b11;
        bus.write_en = 2'b00;
        tick();
        check("ab_rr0",   64'(bus.mem_addr0), 64'h9);
        tick();
        check("ab_rdone", 64'(bus.done), 64'h1);
        check("ab_rdata", 64'(bus.read_data[31:0]), 64'h1234_5678);
        bus.go = 2'b00;
        tick();

        // 6. mem_done stalled 5 cycles
        stall_n        = 5;
        base           = done1_cnt;
        bus.go         = 2'b10;
        bus.write_en   = 2'b10;
        bus.addr0      = {4'd10, 4'd0};
        bus.write_data = {32'hA5A5_A5A5, 32'h0};
        tick();
        check("st_wen", 64'(bus.mem_write_en), 64'h1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("st_hold_done",  64'(bus.done), 64'h0);
            check("st_hold_busy",  64'(bus.busy), 64'h1);
            check("st_hold_wen",   64'(bus.mem_write_en), 64'h0);
            tick();
        end
        check("st_last_wait", 64'(bus.done), 64'h0);
        tick();
        check("st_done",  64'(bus.done), 64'h2);
        bus.go = 2'b00;
        tick();
        check("st_after", 64'(bus.done), 64'h0);
        tick();
        check("st_once",  64'(done1_cnt - base), 64'h1);
        check("st_mem10", 64'(mem[10]), 64'hA5A5_A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
